// File: rtl/pdm_word_decimator.sv
// pdm_word_decimator
// Drives the PDM deserializer through enable/done handshakes, captures each
// finished word, sums the ones-counts of WORDS_PER_SAMPLE words into one
// zero-centred signed PCM sample and presents it on a valid/ready port.
// The sample path is: capture edge -> accumulate/complete edge -> output load
// edge, so a sample appears two edges after its last word is seen.

module pdm_word_decimator #(
    parameter int WORD_LENGTH      = 16,
    parameter int WORDS_PER_SAMPLE = 4,
    parameter int SAMPLE_WIDTH     = 12
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    enable_i,
    output logic                    des_enable_o,
    input  logic                    des_done_i,
    input  logic [WORD_LENGTH-1:0]  des_data_i,
    output logic [SAMPLE_WIDTH-1:0] sample_o,
    output logic                    sample_valid_o,
    input  logic                    sample_ready_i,
    output logic                    overrun_o
);

    localparam int TOTAL_BITS = WORD_LENGTH * WORDS_PER_SAMPLE;
    localparam int POP_W      = $clog2(WORD_LENGTH + 1);
    localparam int ACC_W      = $clog2(TOTAL_BITS + 1);
    localparam int CNT_W      = (WORDS_PER_SAMPLE > 1) ? $clog2(WORDS_PER_SAMPLE) : 1;

    localparam logic [CNT_W-1:0]        LAST_WORD = CNT_W'(WORDS_PER_SAMPLE - 1);
    localparam logic [SAMPLE_WIDTH-1:0] OFFSET    = SAMPLE_WIDTH'(TOTAL_BITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    des_enable_q, des_enable_d;
    logic                    capture_word;

    logic [WORD_LENGTH-1:0]  word_q, word_d;
    logic                    pending_q, pending_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    complete_q, complete_d;
    logic [SAMPLE_WIDTH-1:0] new_sample_q, new_sample_d;

    logic [SAMPLE_WIDTH-1:0] sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    logic [POP_W-1:0]        word_pop;
    logic [ACC_W-1:0]        sum_w;
    logic [SAMPLE_WIDTH-1:0] sample_calc;

    function automatic logic [POP_W-1:0] popcount(input logic [WORD_LENGTH-1:0] w);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < WORD_LENGTH; i++) begin
            n = n + POP_W'(w[i]);
        end
        return n;
    endfunction

    // Ones-count of the captured word, running sum, and the centred sample
    // 2*sum - TOTAL_BITS computed modulo 2^SAMPLE_WIDTH (exact in two's complement).
    assign word_pop    = popcount(word_q);
    assign sum_w       = acc_q + ACC_W'(word_pop);
    assign sample_calc = SAMPLE_WIDTH'({sum_w, 1'b0}) - OFFSET;

    // FSM state register; des_enable_o is registered alongside the state.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            des_enable_q <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state_q      <= state_d;
            des_enable_q <= des_enable_d;
        end
    end

    // FSM next state: enable low forces IDLE; CAPTURE always lasts one cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (des_done_i) state_d = CAPTURE;
                CAPTURE: state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: deserializer enabled exactly while heading into RUN.
    always_comb begin
        des_enable_d = (state_d == RUN);
        capture_word = (state_q == RUN) && (state_d == CAPTURE);
    end

    // Word capture, accumulation and sample completion.
    always_comb begin
        word_d       = word_q;
        pending_d    = 1'b0;
        acc_d        = acc_q;
        count_d      = count_q;
        complete_d   = 1'b0;
        new_sample_d = new_sample_q;
        if (!enable_i) begin
            // Partial sample and any latched word are abandoned.
            acc_d   = '0;
            count_d = '0;
        end else if (pending_q) begin
            if (count_q == LAST_WORD) begin
                complete_d   = 1'b1;
                new_sample_d = sample_calc;
                acc_d        = '0;
                count_d      = '0;
            end else begin
                acc_d   = sum_w;
                count_d = count_q + CNT_W'(1);
            end
        end
        if (capture_word) begin
            word_d    = des_data_i;
            pending_d = 1'b1;
        end
    end

    // Output register: load on empty or same-edge handoff, else drop and flag.
    always_comb begin
        sample_d  = sample_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (complete_q) begin
            if (!valid_q || sample_ready_i) begin
                sample_d = new_sample_q;
                valid_d  = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && sample_ready_i) begin
            valid_d = 1'b0;
        end
        if (!enable_i) begin
            overrun_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            word_q       <= '0;
            pending_q    <= 1'b0;
            acc_q        <= '0;
            count_q      <= '0;
            complete_q   <= 1'b0;
            new_sample_q <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            word_q       <= word_d;
            pending_q    <= pending_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            complete_q   <= complete_d;
            new_sample_q <= new_sample_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign des_enable_o   = des_enable_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_pdm_word_decimator.sv
// Testbench for pdm_word_decimator: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.

module tb_pdm_word_decimator;

    localparam int WL    = 16;
    localparam int WPS   = 4;
    localparam int SW    = 12;
    localparam int TOTAL = WL * WPS;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          enable_i = 1'b0;
    logic          des_enable_o;
    logic          des_done_i = 1'b0;
    logic [WL-1:0] des_data_i = '0;
    logic [SW-1:0] sample_o;
    logic          sample_valid_o;
    logic          sample_ready_i = 1'b0;
    logic          overrun_o;

    pdm_word_decimator #(
        .WORD_LENGTH      (WL),
        .WORDS_PER_SAMPLE (WPS),
        .SAMPLE_WIDTH     (SW)
    ) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .des_enable_o   (des_enable_o),
        .des_done_i     (des_done_i),
        .des_data_i     (des_data_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .overrun_o      (overrun_o)
    );

    always #5 clock_i = ~clock_i;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Words captured from the deserializer are grouped; each full group yields
    // 2*ones - TOTAL, delivered to the output one edge after the group closes.
    logic          m_den;
    logic          m_pend;
    logic [WL-1:0] m_word;
    int            m_sum;
    int            m_cnt;
    logic          m_arrive;
    logic [SW-1:0] m_aval;
    logic          m_valid;
    logic [SW-1:0] m_sample;
    logic          m_ovr;
    int            cyc = 0;
    int            cap_cyc = 0;

    task automatic model_reset();
        m_den = 0; m_pend = 0; m_word = '0; m_sum = 0; m_cnt = 0;
        m_arrive = 0; m_aval = '0; m_valid = 0; m_sample = '0; m_ovr = 0;
    endtask

    task automatic model_edge();
        logic          arrive_n;
        logic [SW-1:0] aval_n;
        arrive_n = 1'b0;
        aval_n   = m_aval;
        if (m_pend && enable_i) begin
            m_sum += $countones(m_word);
            m_cnt++;
            if (m_cnt == WPS) begin
                arrive_n = 1'b1;
                aval_n   = SW'(2 * m_sum - TOTAL);
                m_sum = 0;
                m_cnt = 0;
            end
        end
        if (!enable_i) begin
            m_sum = 0;
            m_cnt = 0;
        end
        if (m_arrive) begin
            if (!m_valid || sample_ready_i) begin
                m_sample = m_aval;
                m_valid  = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && sample_ready_i) begin
            m_valid = 1'b0;
        end
        if (!enable_i) m_ovr = 1'b0;
        if (enable_i && m_den && des_done_i) begin
            if (m_cnt == WPS - 1) cap_cyc = cyc;
            m_word = des_data_i;
            m_pend = 1'b1;
        end else begin
            m_pend = 1'b0;
        end
        m_den    = enable_i && !(m_den && des_done_i);
        m_arrive = arrive_n;
        m_aval   = aval_n;
    endtask

    // ---------------- deserializer stand-in and cycle stepping ----------------
    logic [WL-1:0] feed_q[$];
    logic [SW-1:0] dir_q[$];
    int            des_delay = 0;
    logic          prev_valid = 1'b0;

    task automatic step();
        @(posedge clock_i);
        cyc++;
        model_edge();
        @(negedge clock_i);
        check("des_enable", des_enable_o, m_den);
        check("valid", sample_valid_o, m_valid);
        check("overrun", overrun_o, m_ovr);
        if (m_valid) check("sample", sample_o, m_sample);
        if (!prev_valid && sample_valid_o) begin
            check("latency", cyc - cap_cyc, 2);
            if (dir_q.size() > 0) check("dir_sample", sample_o, dir_q.pop_front());
        end
        prev_valid = sample_valid_o;
        // Deserializer: holds done until its enable drops, then restarts.
        if (!des_enable_o) begin
            des_done_i = 1'b0;
            des_delay  = $urandom_range(0, 3);
        end else if (!des_done_i) begin
            if (des_delay > 0) des_delay--;
            else if (feed_q.size() > 0) begin
                des_data_i = feed_q.pop_front();
                des_done_i = 1'b1;
            end
        end
    endtask

    task automatic feed(input logic [WL-1:0] w, input int n);
        for (int i = 0; i < n; i++) feed_q.push_back(w);
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((feed_q.size() != 0 || des_done_i || m_pend || m_cnt != 0 || m_arrive) && n < budget) begin
            step();
            n++;
        end
        check("run_idle_budget", n < budget, 1);
        step();
        step();
    endtask

    initial begin
        model_reset();
        // Reset state
        #3;
        check("rst_des_enable", des_enable_o, 0);
        check("rst_valid", sample_valid_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_sample", sample_o, 0);
        @(negedge clock_i);
        reset_i  = 1'b0;
        enable_i = 1'b1;
        sample_ready_i = 1'b1;

        // Basic patterns with the sink always ready
        feed(16'hFFFF, 4); dir_q.push_back(12'h040); run_idle(200);
        feed(16'h0000, 4); dir_q.push_back(12'hFC0); run_idle(200);
        feed(16'hAAAA, 4); dir_q.push_back(12'h000); run_idle(200);
        feed(16'hFFFF, 1); feed(16'h0000, 1); feed(16'hFFFF, 1); feed(16'h0000, 1);
        dir_q.push_back(12'h000); run_idle(200);
        feed(16'h000F, 4); dir_q.push_back(12'hFE0); run_idle(200);

        // Sink stalled across two samples: first kept, second dropped
        sample_ready_i = 1'b0;
        feed(16'hFFFF, 4); feed(16'h0000, 4); dir_q.push_back(12'h040);
        run_idle(400);
        check("ovr_hold_sample", sample_o, 12'h040);
        check("ovr_hold_valid", sample_valid_o, 1);
        check("ovr_flag", overrun_o, 1);
        sample_ready_i = 1'b1;
        step();
        check("ovr_drain_valid", sample_valid_o, 0);

        // Same-edge handoff and load
        enable_i = 1'b0; step(); enable_i = 1'b1;
        sample_ready_i = 1'b0;
        feed(16'hFFFF, 4); dir_q.push_back(12'h040); run_idle(200);
        feed(16'h0000, 4);
        for (int n = 0; n < 200 && !m_arrive; n++) step();
        check("handoff_arrive_seen", m_arrive, 1);
        sample_ready_i = 1'b1;
        step();
        check("handoff_valid", sample_valid_o, 1);
        check("handoff_sample", sample_o, 12'hFC0);
        check("handoff_overrun", overrun_o, 0);
        run_idle(200);

        // Enable dropped after two words: partial sample discarded
        feed(16'hFFFF, 4);
        for (int n = 0; n < 200 && m_cnt != 2; n++) step();
        check("partial_two_words", m_cnt, 2);
        enable_i = 1'b0;
        feed_q.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            check("disabled_des_enable", des_enable_o, 0);
        end
        enable_i = 1'b1;
        feed(16'h0000, 4); dir_q.push_back(12'hFC0); run_idle(200);

        // Asynchronous reset while in CAPTURE with a held sample
        sample_ready_i = 1'b0;
        feed(16'hFFFF, 4); dir_q.push_back(12'h040); run_idle(200);
        feed(16'hFFFF, 2);
        for (int n = 0; n < 200 && !m_pend; n++) step();
        check("capture_reached", m_pend, 1);
        check("pre_reset_valid", sample_valid_o, 1);
        #2 reset_i = 1'b1;
        #1;
        check("async_des_enable", des_enable_o, 0);
        check("async_valid", sample_valid_o, 0);
        check("async_overrun", overrun_o, 0);
        check("async_sample", sample_o, 0);
        #1 reset_i = 1'b0;
        model_reset();
        feed_q.delete();
        des_done_i = 1'b0;
        prev_valid = 1'b0;
        step();
        check("post_reset_des_enable", des_enable_o, 1);
        check("dir_all_seen", dir_q.size(), 0);

        // Randomized traffic
        sample_ready_i = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            enable_i = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 15) == 0) sample_ready_i = ~sample_ready_i;
            if (feed_q.size() < 2) begin
                case ($urandom_range(0, 3))
                    0:       feed_q.push_back(16'hFFFF);
                    1:       feed_q.push_back(16'h0000);
                    default: feed_q.push_back(WL'($urandom));
                endcase
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pdm_word_decimator.md
Name: pdm_word_decimator

Overview:
- Downstream stage of the PDM microphone deserializer.
- Sequences the deserializer through enable/done cycles and captures each completed PDM word.
- Converts each word to a ones-count, then sums WORDS_PER_SAMPLE consecutive words into one signed, zero-centred PCM sample.
- Delivers each sample over a valid/ready handshake to the audio sink.

Parameters:
- WORD_LENGTH, 16: width of a deserialized PDM word.
- WORDS_PER_SAMPLE, 4: words summed per output sample; must be ≥1.
- SAMPLE_WIDTH, 12: signed output width; must be ≥ clog2(WORD_LENGTH*WORDS_PER_SAMPLE)+2.

Ports:
- clock_i  in  1  100 MHz system clock.
- reset_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  block run enable from the Controller.
- des_enable_o  out  1  enable to the deserializer (registered).
- des_done_i  in  1  deserializer word-ready; level, held until des_enable_o drops.
- des_data_i  in  WORD_LENGTH  deserialized PDM word; valid while des_done_i is high.
- sample_o  out  SAMPLE_WIDTH  signed PCM sample.
- sample_valid_o  out  1  sample_o holds an unconsumed sample.
- sample_ready_i  in  1  sink accepts the sample.
- overrun_o  out  1  sticky: a completed sample was dropped.

Behaviour:
- One clock domain: clock_i. Reset is asynchronous and active-high on reset_i.
- Reset values: des_enable_o=0, sample_o=0, sample_valid_o=0, overrun_o=0. Internal state: FSM=IDLE, accumulator=0, word count=0, pending-word flag=0.
- FSM states: IDLE, RUN, CAPTURE.
  - IDLE: des_enable_o=0. Goes to RUN when enable_i=1; des_enable_o=1 from that edge.
  - RUN, edge with des_done_i=1: latch des_data_i into word register, set pending-word flag, go to CAPTURE, des_enable_o<=0.
  - CAPTURE (always exactly 1 cycle): go to RUN, des_enable_o<=1. The deserializer therefore sees enable low for exactly one cycle, which clears its done signal and restarts it.
- Accumulate (next edge after a latch, i.e. the CAPTURE→RUN edge):
  - acc <= acc + popcount(word register); popcount range is 0..WORD_LENGTH.
  - word count increments and clears the pending-word flag.
- Sample completion: when the word being accumulated is the WORDS_PER_SAMPLE-th, on that same edge:
  - Compute S = 2*(acc+popcount) − WORD_LENGTH*WORDS_PER_SAMPLE, sign-extended to SAMPLE_WIDTH.
  - Range with defaults: −64..+64.
  - Clear acc and word count.
- Sample latency: sample_valid_o rises 2 edges after the edge that samples des_done_i high for the final word.
- Output handshake:
  - Transfer occurs on any edge with sample_valid_o=1 and sample_ready_i=1.
  - sample_o is stable while sample_valid_o=1 and sample_ready_i=0.
  - New sample completes while the register is empty, or a transfer occurs on the same edge: load sample_o, sample_valid_o=1. No bubble on simultaneous handoff and load.
  - New sample completes while holding an unaccepted sample with sample_ready_i=0: discard the new sample, keep the old one, set overrun_o=1.
  - Transfer with no new sample: sample_valid_o<=0.
- enable_i deasserted:
  - From any state, next edge: FSM=IDLE, des_enable_o=0; acc, word count and pending-word flag cleared (partial sample discarded); overrun_o cleared.
  - A held sample_o/sample_valid_o is kept until consumed.
- enable_i deasserted during CAPTURE: the latched word is discarded.
- des_done_i is ignored in IDLE and CAPTURE.
- reset_i asserted mid-operation: all state returns to reset values immediately, asynchronously.

Test Plan:
- WORDS_PER_SAMPLE=4; four words 0xFFFF -> sample_o=+64 (0x040), sample_valid_o high 2 edges after the 4th des_done_i sample; des_enable_o low exactly 1 cycle per word.
- Four words 0x0000 -> sample_o=−64 (0xFC0). Four words 0xAAAA -> 0. Sequence 0xFFFF,0x0000,0xFFFF,0x0000 -> 0. Four words 0x000F -> −32 (0xFE0).
- sample_ready_i=0 across two completed samples (+64 then −64) -> sample_o stays +64, overrun_o=1; then ready=1 for one cycle -> transfer, sample_valid_o=0.
- sample_ready_i=1 on the same edge a new sample completes -> old sample transfers, new sample loads, sample_valid_o stays 1, overrun_o stays 0.
- enable_i dropped after 2 of 4 words (0xFFFF), then re-enabled with four words 0x0000 -> partial discarded, sample_o=−64, des_enable_o=0 while disabled.
- reset_i pulsed mid-CAPTURE -> all outputs 0 immediately, without waiting for a clock edge; after release with enable_i=1, des_enable_o rises on the first edge.
